// File: rtl/ahb_master_burst_driver.sv
`default_nettype none
// ============================================================================
// Module      : ahb_master_burst_driver
// Description : AHB master address-phase generator. Accepts one burst request
//               at a time and drives haddr/htrans/hburst/hsize/hwrite beat by
//               beat. Computes INCR and WRAP addresses, inserts requested BUSY
//               cycles, honours hready wait states and aborts on ERROR.
// Ports       : hclk, hresetn           - clock, async active-low reset
//               req_valid/req_ready     - request handshake (ready = idle)
//               req_addr/burst/size/write/len/busy - latched burst request
//               haddr/htrans/hburst/hsize/hwrite   - AHB address phase
//               hready, hresp           - AHB transfer response
//               done, err               - one-cycle completion pulse + status
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_master_burst_driver #(
    parameter int ADDR_WIDTH = 32,
    parameter int LENGTH     = 4
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [2:0]             req_burst,
    input  logic [2:0]             req_size,
    input  logic                   req_write,
    input  logic [LENGTH:0]        req_len,
    input  logic [2**LENGTH-1:0]   req_busy,
    output logic [ADDR_WIDTH-1:0]  haddr,
    output logic [1:0]             htrans,
    output logic [2:0]             hburst,
    output logic [2:0]             hsize,
    output logic                   hwrite,
    input  logic                   hready,
    input  logic                   hresp,
    output logic                   done,
    output logic                   err
);

    localparam logic [1:0] c_trans_idle   = 2'b00;
    localparam logic [1:0] c_trans_busy   = 2'b01;
    localparam logic [1:0] c_trans_nonseq = 2'b10;
    localparam logic [1:0] c_trans_seq    = 2'b11;

    localparam logic [2:0] c_burst_single = 3'b000;
    localparam logic [2:0] c_size_byte    = 3'b000;
    localparam logic       c_write_read   = 1'b0;

    localparam logic [LENGTH:0]     c_max_beats = (LENGTH+1)'(2**LENGTH);
    localparam logic [ADDR_WIDTH-1:0] c_one     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_BUSY      = 3'd2,
        ST_LAST_DATA = 3'd3,
        ST_ERR       = 3'd4
    } state_t;

    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH-1:0]   haddr_q,  haddr_d;
    logic [1:0]              htrans_q, htrans_d;
    logic [2:0]              hburst_q, hburst_d;
    logic [2:0]              hsize_q,  hsize_d;
    logic                    hwrite_q, hwrite_d;
    logic [LENGTH:0]         beats_q,  beats_d;   // total beats in burst
    logic [LENGTH:0]         beat_q,   beat_d;    // index of beat on the bus
    logic [2**LENGTH-1:0]    busy_q,   busy_d;
    logic                    dphase_q, dphase_d;  // a beat is in its data phase
    logic                    done_q,   done_d;
    logic                    err_q,    err_d;

    // Request decode
    logic [LENGTH:0]         w_req_beats;
    logic [ADDR_WIDTH-1:0]   w_req_incr;
    logic [ADDR_WIDTH-1:0]   w_req_aligned;

    // Next-address computation for the active burst
    logic [ADDR_WIDTH-1:0]   w_incr;
    logic [ADDR_WIDTH-1:0]   w_wrap_mask;
    logic [ADDR_WIDTH-1:0]   w_addr_inc;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic                    w_is_wrap;
    logic [LENGTH:0]         w_beat_next;
    logic                    w_last_beat;

    always_comb begin
        w_req_beats = c_max_beats;
        case (req_burst)
            3'b000:        w_req_beats = (LENGTH+1)'(1);
            3'b001: begin
                if (req_len == '0)
                    w_req_beats = (LENGTH+1)'(1);
                else if (req_len > c_max_beats)
                    w_req_beats = c_max_beats;
                else
                    w_req_beats = req_len;
            end
            3'b010, 3'b011: w_req_beats = (LENGTH+1)'(4);
            3'b100, 3'b101: w_req_beats = (LENGTH+1)'(8);
            default:        w_req_beats = (LENGTH+1)'(16);
        endcase
    end

    assign w_req_incr    = c_one << req_size;
    assign w_req_aligned = req_addr & ~(w_req_incr - c_one);

    // WRAP bursts have an even, non-zero hburst code.
    assign w_is_wrap   = (hburst_q != c_burst_single) && !hburst_q[0];
    assign w_incr      = c_one << hsize_q;
    assign w_wrap_mask = (ADDR_WIDTH'(beats_q) << hsize_q) - c_one;
    assign w_addr_inc  = haddr_q + w_incr;
    assign w_next_addr = w_is_wrap ? ((haddr_q & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask))
                                   : w_addr_inc;

    assign w_beat_next = beat_q + (LENGTH+1)'(1);
    assign w_last_beat = (w_beat_next == beats_q);

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hburst_d = hburst_q;
        hsize_d  = hsize_q;
        hwrite_d = hwrite_q;
        beats_d  = beats_q;
        beat_d   = beat_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        // A completed data phase retires unless a new address is accepted.
        dphase_d = hready ? 1'b0 : dphase_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_ADDR;
                    haddr_d  = w_req_aligned;
                    htrans_d = c_trans_nonseq;
                    hburst_d = req_burst;
                    hsize_d  = req_size;
                    hwrite_d = req_write;
                    beats_d  = w_req_beats;
                    beat_d   = '0;
                    busy_d   = req_busy;
                    dphase_d = 1'b0;
                end
            end

            ST_ADDR: begin
                if (dphase_q && hresp) begin
                    state_d  = ST_ERR;
                    htrans_d = c_trans_idle;
                end else if (hready) begin
                    dphase_d = 1'b1;
                    if (w_last_beat) begin
                        state_d  = ST_LAST_DATA;
                        htrans_d = c_trans_idle;
                    end else begin
                        beat_d  = w_beat_next;
                        haddr_d = w_next_addr;
                        // Not last, so the next index is below 2**LENGTH.
                        if (busy_q[w_beat_next[LENGTH-1:0]]) begin
                            state_d  = ST_BUSY;
                            htrans_d = c_trans_busy;
                        end else begin
                            htrans_d = c_trans_seq;
                        end
                    end
                end
            end

            ST_BUSY: begin
                if (dphase_q && hresp) begin
                    state_d  = ST_ERR;
                    htrans_d = c_trans_idle;
                end else if (hready) begin
                    state_d  = ST_ADDR;
                    htrans_d = c_trans_seq;
                end
            end

            ST_LAST_DATA: begin
                if (hresp) begin
                    state_d = ST_ERR;
                end else if (hready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_ERR: begin
                htrans_d = c_trans_idle;
                if (hready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                htrans_d = c_trans_idle;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            htrans_q <= c_trans_idle;
            hburst_q <= c_burst_single;
            hsize_q  <= c_size_byte;
            hwrite_q <= c_write_read;
            beats_q  <= '0;
            beat_q   <= '0;
            busy_q   <= '0;
            dphase_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hburst_q <= hburst_d;
            hsize_q  <= hsize_d;
            hwrite_q <= hwrite_d;
            beats_q  <= beats_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            dphase_q <= dphase_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hburst    = hburst_q;
    assign hsize     = hsize_q;
    assign hwrite    = hwrite_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire
